// File: rtl/display_channel_selector.sv
// Debounced, edge-triggered channel navigator with freeze for the 7-segment display path.
// Optional macro DISPLAY_AUTOSCAN_EN adds the auto_en port and a timed channel scan.

module display_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // press is registered on the 0->1 update of the stable level; releases only move stable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync   <= '0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= sync[1];
        press  <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module display_channel_selector #(
  parameter int NUM_CH          = 4,
  parameter int SEL_W           = 2,
  parameter int DATA_W          = 32,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_TICKS      = 200000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     btn_home,
  input  logic                     btn_next,
  input  logic                     btn_prev,
  input  logic                     btn_freeze,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
`ifdef DISPLAY_AUTOSCAN_EN
  input  logic                     auto_en,
`endif
  output logic [DATA_W-1:0]        disp_data,
  output logic [SEL_W-1:0]         cur_ch,
  output logic                     frozen,
  output logic                     ch_changed
);
  localparam int NUM_BTN = 4;
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(NUM_CH - 1);

  typedef struct packed {
    logic freeze;
    logic prev;
    logic next;
    logic home;
  } btn_t;

  if (NUM_CH < 2 || NUM_CH > 2**SEL_W || DEBOUNCE_CYCLES < 2 || SCAN_TICKS < 2) begin : g_bad_param
    $error("display_channel_selector: illegal parameterisation");
  end

  logic [NUM_BTN-1:0] raw, pressed;
  btn_t               p;

  assign raw = {btn_freeze, btn_prev, btn_next, btn_home};
  assign p   = pressed;

  display_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
    .clk   (clk),
    .reset (reset),
    .btn   (raw),
    .press (pressed)
  );

  logic [NUM_CH-1:0][DATA_W-1:0] ch_arr;
  logic [SEL_W-1:0]              ch_inc, ch_dec, ch_nx;
  logic                          any_nav, ch_move, frozen_nx, scan_tick;

  assign ch_arr  = ch_data;
  assign ch_inc  = (cur_ch == CH_LAST) ? '0 : cur_ch + 1'b1;
  assign ch_dec  = (cur_ch == '0) ? CH_LAST : cur_ch - 1'b1;
  assign any_nav = p.home | p.next | p.prev;

`ifdef DISPLAY_AUTOSCAN_EN
  localparam int SCAN_W = $clog2(SCAN_TICKS);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TICKS - 1);

  logic [SCAN_W-1:0] scan_cnt;

  assign scan_tick = auto_en & ~frozen & (scan_cnt == SCAN_LAST);

  // any accepted press restarts the dwell, so a manual move is never followed by an early scan step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
    end else if (!auto_en || (|pressed) || (frozen_nx & ~frozen)) begin
      scan_cnt <= '0;
    end else if (!frozen) begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
    end
  end
`else
  assign scan_tick = 1'b0;
`endif

  always_comb begin
    ch_nx = cur_ch;
    if (p.home)                 ch_nx = '0;
    else if (p.next & ~p.prev)  ch_nx = ch_inc;
    else if (p.prev & ~p.next)  ch_nx = ch_dec;
    else if (!any_nav && scan_tick) ch_nx = ch_inc;
    ch_move = (ch_nx != cur_ch);

    frozen_nx = frozen;
    if (p.freeze) frozen_nx = any_nav ? 1'b0 : ~frozen;
    if (ch_move)  frozen_nx = 1'b0;
  end

  // disp_data holds from the very edge freeze is entered, using the next-state flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_ch     <= '0;
      disp_data  <= '0;
      frozen     <= 1'b0;
      ch_changed <= 1'b0;
    end else begin
      cur_ch     <= ch_nx;
      ch_changed <= ch_move;
      frozen     <= frozen_nx;
      if (!frozen_nx) disp_data <= ch_arr[cur_ch];
    end
  end
endmodule
